// File: rtl/gb_cpu_fetch_if.sv
// Bus bundle between the fetch unit, the memory read port, the execute-stage
// redirect and the decoder handshake.
interface gb_cpu_fetch_if;
    logic [15:0] mem_addr;
    logic        mem_rd_req;
    logic [7:0]  mem_rd_data;
    logic        mem_rd_valid;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic        instr_valid;
    logic        instr_ready;
    logic [23:0] instruction;
    logic [15:0] instr_pc;
    logic [1:0]  instr_len;

    modport master (
        output mem_addr, mem_rd_req, instr_valid, instruction, instr_pc, instr_len,
        input  mem_rd_data, mem_rd_valid, pc_load, pc_load_value, instr_ready
    );

    modport slave (
        input  mem_addr, mem_rd_req, instr_valid, instruction, instr_pc, instr_len,
        output mem_rd_data, mem_rd_valid, pc_load, pc_load_value, instr_ready
    );
endinterface

// File: rtl/gb_cpu_fetch.sv
// Game Boy CPU instruction fetch: reads 1-3 bytes starting at the PC and
// hands the packed instruction word to the decoder over valid/ready.
module gb_cpu_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst_n,
    gb_cpu_fetch_if.master  bus
);

    typedef enum logic [2:0] {
        ST_START,
        ST_F0,
        ST_F1,
        ST_F2,
        ST_HOLD
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic        r_req;
    logic        r_valid;
    logic [23:0] r_instr;
    logic [15:0] r_instr_pc;
    logic [1:0]  r_len;

    logic        w_xfer;
    logic [7:0]  w_byte;

    function automatic logic [1:0] len_of(input logic [7:0] op);
        logic [1:0] len;
        len = 2'd1;
        if ((op[7:6] == 2'b00 && op[3:0] == 4'h1) || op == 8'h08 ||
            (op[7:5] == 3'b110 && (op[2:0] == 3'b010 || op[2:0] == 3'b100)) ||
            op == 8'hC3 || op == 8'hCD || op == 8'hEA || op == 8'hFA)
            len = 2'd3;
        else if ((op[7:6] == 2'b00 && op[2:0] == 3'b110) ||
                 op == 8'h10 || op == 8'h18 || op == 8'h20 || op == 8'h28 ||
                 op == 8'h30 || op == 8'h38 || op == 8'hCB ||
                 (op[7:6] == 2'b11 && op[2:0] == 3'b110) ||
                 op == 8'hE0 || op == 8'hF0 || op == 8'hE8 || op == 8'hF8)
            len = 2'd2;
        return len;
    endfunction

    assign w_xfer = r_req && bus.mem_rd_valid;
    assign w_byte = bus.mem_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_START;
            r_pc       <= RESET_PC;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_instr    <= 24'h0;
            r_instr_pc <= RESET_PC;
            r_len      <= 2'd0;
        end else if (bus.pc_load) begin
            // Redirect wins over any transfer or partial instruction; a HOLD
            // handshake in the same cycle is simply treated as accepted.
            r_pc    <= bus.pc_load_value;
            r_state <= ST_F0;
            r_req   <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_START: begin
                    r_state <= ST_F0;
                    r_req   <= 1'b1;
                end
                ST_F0: if (w_xfer) begin
                    r_instr    <= {w_byte, 16'h0000};
                    r_instr_pc <= r_pc;
                    r_pc       <= r_pc + 16'd1;
                    r_len      <= len_of(w_byte);
                    if (len_of(w_byte) == 2'd1) begin
                        r_state <= ST_HOLD;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= ST_F1;
                    end
                end
                ST_F1: if (w_xfer) begin
                    r_instr[15:8] <= w_byte;
                    r_pc          <= r_pc + 16'd1;
                    if (r_len == 2'd2) begin
                        r_state <= ST_HOLD;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= ST_F2;
                    end
                end
                ST_F2: if (w_xfer) begin
                    r_instr[7:0] <= w_byte;
                    r_pc         <= r_pc + 16'd1;
                    r_state      <= ST_HOLD;
                    r_req        <= 1'b0;
                    r_valid      <= 1'b1;
                end
                ST_HOLD: if (bus.instr_ready) begin
                    r_state <= ST_F0;
                    r_req   <= 1'b1;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_START;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // The PC register doubles as the request address; it only moves on a
    // completed transfer or a redirect, which keeps mem_addr stable while waiting.
    assign bus.mem_addr    = r_pc;
    assign bus.mem_rd_req  = r_req;
    assign bus.instr_valid = r_valid;
    assign bus.instruction = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_len   = r_len;

endmodule

// File: tb/tb_gb_cpu_fetch.sv
// Directed bench for gb_cpu_fetch with a wait-state programmable memory model.
module tb_gb_cpu_fetch;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   waits;

    logic [7:0]  mem [0:65535];
    logic [15:0] last_addr;
    logic        last_req;
    int          cnt;
    int          eff_cnt;
    logic        xfer;

    gb_cpu_fetch_if bus ();

    gb_cpu_fetch #(.RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: a request is served once it has been held on the same
    // address for `waits` extra cycles.
    assign eff_cnt          = (last_req && bus.mem_addr == last_addr) ? cnt : 0;
    assign bus.mem_rd_valid = bus.mem_rd_req && (eff_cnt >= waits);
    assign bus.mem_rd_data  = mem[bus.mem_addr];
    assign xfer             = bus.mem_rd_req && bus.mem_rd_valid;

    always @(posedge clk) begin
        last_addr <= bus.mem_addr;
        last_req  <= bus.mem_rd_req;
        if (xfer || !bus.mem_rd_req)
            cnt <= 0;
        else if (!(last_req && bus.mem_addr == last_addr))
            cnt <= 1;
        else
            cnt <= cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_instr(input string tag, input logic [23:0] ins,
                               input logic [15:0] pc, input logic [1:0] len);
        check({tag, " valid"}, {23'h0, bus.instr_valid}, 24'h1);
        check({tag, " instr"}, bus.instruction, ins);
        check({tag, " pc"},    {8'h0, bus.instr_pc}, {8'h0, pc});
        check({tag, " len"},   {22'h0, bus.instr_len}, {22'h0, len});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        waits   = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0100] = 8'hC3; mem[16'h0101] = 8'h50; mem[16'h0102] = 8'h01;
        mem[16'h0103] = 8'hCB; mem[16'h0104] = 8'h7C; mem[16'h0105] = 8'hE2;
        mem[16'h0106] = 8'h3E; mem[16'h0107] = 8'h42;
        mem[16'h0200] = 8'h21; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12;
        mem[16'h0203] = 8'h01; mem[16'h0204] = 8'hAA; mem[16'h0205] = 8'hBB;
        mem[16'hFFFE] = 8'hCD; mem[16'hFFFF] = 8'h00;

        rst_n = 1'b0;
        bus.pc_load = 1'b0;
        bus.pc_load_value = 16'h0000;
        bus.instr_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("rst req",   {23'h0, bus.mem_rd_req}, 24'h0);
        check("rst addr",  {8'h0, bus.mem_addr}, 24'h0000);
        check("rst valid", {23'h0, bus.instr_valid}, 24'h0);
        check("rst instr", bus.instruction, 24'h0);
        check("rst ipc",   {8'h0, bus.instr_pc}, 24'h0000);
        check("rst len",   {22'h0, bus.instr_len}, 24'h0);

        // 1: START -> F0 at 0000, one-byte NOP
        rst_n = 1'b1;
        tick();
        check("t1 f0 req",  {23'h0, bus.mem_rd_req}, 24'h1);
        check("t1 f0 addr", {8'h0, bus.mem_addr}, 24'h0000);
        tick();
        check_instr("t1", 24'h000000, 16'h0000, 2'd1);
        check("t1 hold req", {23'h0, bus.mem_rd_req}, 24'h0);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check("t1 next addr", {8'h0, bus.mem_addr}, 24'h0001);

        // 2: redirect to 0100, JP a16
        bus.pc_load = 1'b1;
        bus.pc_load_value = 16'h0100;
        tick();
        bus.pc_load = 1'b0;
        check("t2 redir addr",  {8'h0, bus.mem_addr}, 24'h0100);
        check("t2 redir valid", {23'h0, bus.instr_valid}, 24'h0);
        tick(); tick();
        check("t2 early valid", {23'h0, bus.instr_valid}, 24'h0);
        tick();
        check_instr("t2", 24'hC35001, 16'h0100, 2'd3);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check("t2 next addr", {8'h0, bus.mem_addr}, 24'h0103);

        // 3: CB 7C / E2 / 3E 42
        tick(); tick();
        check_instr("t3a", 24'hCB7C00, 16'h0103, 2'd2);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        tick();
        check_instr("t3b", 24'hE20000, 16'h0105, 2'd1);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        tick(); tick();
        check_instr("t3c", 24'h3E4200, 16'h0106, 2'd2);

        // 5: stall in HOLD for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check_instr("t5 stall", 24'h3E4200, 16'h0106, 2'd2);
            check("t5 stall req", {23'h0, bus.mem_rd_req}, 24'h0);
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check("t5 resume req",  {23'h0, bus.mem_rd_req}, 24'h1);
        check("t5 resume addr", {8'h0, bus.mem_addr}, 24'h0108);

        // 4: redirect to 0200 with two wait states per byte
        waits = 2;
        bus.pc_load = 1'b1;
        bus.pc_load_value = 16'h0200;
        tick();
        bus.pc_load = 1'b0;
        check("t4 f0 addr", {8'h0, bus.mem_addr}, 24'h0200);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("t4 wait addr", {8'h0, bus.mem_addr},
                  (i < 3) ? 24'h0200 : (i < 6) ? 24'h0201 : 24'h0202);
            check("t4 wait req",   {23'h0, bus.mem_rd_req}, 24'h1);
            check("t4 wait valid", {23'h0, bus.instr_valid}, 24'h0);
        end
        tick();
        check_instr("t4", 24'h213412, 16'h0200, 2'd3);

        // 6: redirect during F1 of a 3-byte fetch, then fetch across the wrap
        waits = 0;
        mem[16'h0000] = 8'hC0;
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check("t6 f0 addr", {8'h0, bus.mem_addr}, 24'h0203);
        tick();
        check("t6 f1 addr", {8'h0, bus.mem_addr}, 24'h0204);
        bus.pc_load = 1'b1;
        bus.pc_load_value = 16'hFFFE;
        tick();
        bus.pc_load = 1'b0;
        check("t6 redir addr",  {8'h0, bus.mem_addr}, 24'hFFFE);
        check("t6 redir valid", {23'h0, bus.instr_valid}, 24'h0);
        tick();
        check("t6 addr ffff", {8'h0, bus.mem_addr}, 24'hFFFF);
        tick();
        check("t6 addr 0000", {8'h0, bus.mem_addr}, 24'h0000);
        tick();
        check_instr("t6", 24'hCD00C0, 16'hFFFE, 2'd3);

        // Handshake and redirect together in HOLD
        bus.instr_ready = 1'b1;
        bus.pc_load = 1'b1;
        bus.pc_load_value = 16'h0300;
        tick();
        bus.instr_ready = 1'b0;
        bus.pc_load = 1'b0;
        check("hs+redir addr",  {8'h0, bus.mem_addr}, 24'h0300);
        check("hs+redir valid", {23'h0, bus.instr_valid}, 24'h0);
        check("hs+redir req",   {23'h0, bus.mem_rd_req}, 24'h1);

        // Asynchronous reset mid-fetch
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst req",   {23'h0, bus.mem_rd_req}, 24'h0);
        check("arst addr",  {8'h0, bus.mem_addr}, 24'h0000);
        check("arst instr", bus.instruction, 24'h0);
        check("arst ipc",   {8'h0, bus.instr_pc}, 24'h0000);
        check("arst len",   {22'h0, bus.instr_len}, 24'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
